// File: rtl/alu_result_packer.sv
// rtl/alu_result_packer.sv - captures ALU result words and streams their bytes LSB-first into the TX FIFO
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   ALU_OUT    ALU result word, valid while OUT_Valid=1
//   OUT_Valid  single-cycle result strobe
//   BYTE_LEN   number of bytes to send minus one, sampled with ALU_OUT
//   FIFO_FULL  TX FIFO full; suppresses writes
//   WR_DATA    byte presented to the FIFO (0 when not sending)
//   WR_INC     FIFO write enable, one byte per high cycle
//   BUSY       high while a result is being sent
//   DONE       pulses in the cycle the last byte of a result is written
//   DROP_CNT   results dropped while busy, saturating at 255

module alu_result_packer #(
    parameter int ALU_WIDTH = 32,
    parameter int NUM_BYTES = ALU_WIDTH / 8,
    parameter int LEN_WIDTH = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ALU_WIDTH-1:0] ALU_OUT,
    input  logic                 OUT_Valid,
    input  logic [LEN_WIDTH-1:0] BYTE_LEN,
    input  logic                 FIFO_FULL,
    output logic [7:0]           WR_DATA,
    output logic                 WR_INC,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [7:0]           DROP_CNT
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // One extra bit so the counter can hold BYTE_LEN+1 at its largest value.
    localparam int CNT_W = LEN_WIDTH + 1;

    logic [0:0]           state;
    logic [ALU_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]     byte_cnt;
    logic [7:0]           drop_cnt;

    logic [CNT_W-1:0]     load_cnt;
    logic                 in_send;
    logic                 write;
    logic                 last_write;

    // Requests longer than the word are clamped to a full-word send.
    always_comb begin
        load_cnt = CNT_W'(NUM_BYTES);
        if ({1'b0, BYTE_LEN} < CNT_W'(NUM_BYTES)) begin
            load_cnt = {1'b0, BYTE_LEN} + CNT_W'(1);
        end
    end

    assign in_send    = (state == SEND);
    // Gating with RST keeps the reset cycle write-free even when the
    // state register still says SEND.
    assign write      = in_send & ~FIFO_FULL & ~RST;
    assign last_write = write & (byte_cnt == CNT_W'(1));

    assign WR_INC   = write;
    assign DONE     = last_write;
    assign BUSY     = in_send;
    assign WR_DATA  = in_send ? shift_reg[7:0] : 8'h00;
    assign DROP_CNT = drop_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            byte_cnt  <= '0;
            drop_cnt  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (OUT_Valid) begin
                        shift_reg <= ALU_OUT;
                        byte_cnt  <= load_cnt;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (write) begin
                        shift_reg <= shift_reg >> 8;
                        byte_cnt  <= byte_cnt - CNT_W'(1);
                    end
                    if (last_write) begin
                        // A strobe coinciding with the final write is
                        // accepted directly, giving back-to-back sends.
                        if (OUT_Valid) begin
                            shift_reg <= ALU_OUT;
                            byte_cnt  <= load_cnt;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (OUT_Valid && (drop_cnt != 8'hFF)) begin
                        drop_cnt <= drop_cnt + 8'h01;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_packer.sv
// tb/tb_alu_result_packer.sv - directed self-checking bench for alu_result_packer

module tb_alu_result_packer;

    logic        CLK;
    logic        RST;
    logic [31:0] ALU_OUT;
    logic        OUT_Valid;
    logic [1:0]  BYTE_LEN;
    logic        FIFO_FULL;
    logic [7:0]  WR_DATA;
    logic        WR_INC;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  DROP_CNT;

    int vectors;
    int miscompares;
    int writes;

    alu_result_packer #(.ALU_WIDTH(32), .NUM_BYTES(4), .LEN_WIDTH(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .ALU_OUT   (ALU_OUT),
        .OUT_Valid (OUT_Valid),
        .BYTE_LEN  (BYTE_LEN),
        .FIFO_FULL (FIFO_FULL),
        .WR_DATA   (WR_DATA),
        .WR_INC    (WR_INC),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .DROP_CNT  (DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step past the next rising edge; inputs are then driven for the new cycle.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] data, input logic inc,
                           input logic busy, input logic done);
        chk({tag, ".WR_DATA"}, {24'h0, WR_DATA}, {24'h0, data});
        chk({tag, ".WR_INC"},  {31'h0, WR_INC},  {31'h0, inc});
        chk({tag, ".BUSY"},    {31'h0, BUSY},    {31'h0, busy});
        chk({tag, ".DONE"},    {31'h0, DONE},    {31'h0, done});
    endtask

    logic [7:0] exp_bytes [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        writes      = 0;
        RST         = 1'b1;
        ALU_OUT     = 32'h0;
        OUT_Valid   = 1'b0;
        BYTE_LEN    = 2'd0;
        FIFO_FULL   = 1'b0;

        // Reset then idle
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            settle();
            chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
            chk("reset.DROP_CNT", {24'h0, DROP_CNT}, 32'd0);
        end
        next_cycle();
        RST = 1'b0;
        settle();
        chk_out("idle", 8'h00, 1'b0, 1'b0, 1'b0);

        // Full word, no stalls
        next_cycle();
        ALU_OUT = 32'hA1B2C3D4; BYTE_LEN = 2'd3; OUT_Valid = 1'b1;
        settle();
        chk_out("full.strobe", 8'h00, 1'b0, 1'b0, 1'b0);
        exp_bytes[0] = 8'hD4; exp_bytes[1] = 8'hC3; exp_bytes[2] = 8'hB2; exp_bytes[3] = 8'hA1;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            OUT_Valid = 1'b0; ALU_OUT = 32'h0;
            settle();
            chk_out($sformatf("full.b%0d", i), exp_bytes[i], 1'b1, 1'b1, (i == 3));
        end
        next_cycle();
        settle();
        chk_out("full.after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Short result with a 3-cycle stall
        ALU_OUT = 32'h00001234; BYTE_LEN = 2'd1; OUT_Valid = 1'b1; FIFO_FULL = 1'b1;
        settle();
        writes = 0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            OUT_Valid = 1'b0;
            settle();
            if (WR_INC) writes++;
            chk_out($sformatf("stall.s%0d", i), 8'h34, 1'b0, 1'b1, 1'b0);
        end
        exp_bytes[0] = 8'h34; exp_bytes[1] = 8'h12;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            FIFO_FULL = 1'b0;
            settle();
            if (WR_INC) writes++;
            chk_out($sformatf("stall.b%0d", i), exp_bytes[i], 1'b1, 1'b1, (i == 1));
        end
        next_cycle();
        settle();
        if (WR_INC) writes++;
        chk_out("stall.after", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("stall.writes", writes, 32'd2);

        // Drops while permanently stalled, saturating at 255
        ALU_OUT = 32'h55667788; BYTE_LEN = 2'd2; OUT_Valid = 1'b1; FIFO_FULL = 1'b1;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            ALU_OUT = 32'hDEADBEEF; BYTE_LEN = 2'd3; OUT_Valid = 1'b1;
            settle();
            if (i == 100) chk("drop.mid", {24'h0, DROP_CNT}, 32'd100);
        end
        next_cycle();
        OUT_Valid = 1'b0;
        settle();
        chk("drop.sat", {24'h0, DROP_CNT}, 32'd255);
        chk_out("drop.held", 8'h88, 1'b0, 1'b1, 1'b0);
        exp_bytes[0] = 8'h88; exp_bytes[1] = 8'h77; exp_bytes[2] = 8'h66;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            FIFO_FULL = 1'b0;
            settle();
            chk_out($sformatf("drop.b%0d", i), exp_bytes[i], 1'b1, 1'b1, (i == 2));
        end
        next_cycle();
        settle();
        chk_out("drop.after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset mid-send after two of four bytes
        ALU_OUT = 32'h11223344; BYTE_LEN = 2'd3; OUT_Valid = 1'b1;
        exp_bytes[0] = 8'h44; exp_bytes[1] = 8'h33;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            OUT_Valid = 1'b0;
            settle();
            chk_out($sformatf("rst.b%0d", i), exp_bytes[i], 1'b1, 1'b1, 1'b0);
        end
        next_cycle();
        RST = 1'b1;
        settle();
        chk("rst.cycle.WR_INC", {31'h0, WR_INC}, 32'd0);
        next_cycle();
        RST = 1'b0;
        settle();
        chk_out("rst.after", 8'h00, 1'b0, 1'b0, 1'b0);
        chk("rst.DROP_CNT", {24'h0, DROP_CNT}, 32'd0);
        next_cycle();
        settle();
        chk_out("rst.quiet", 8'h00, 1'b0, 1'b0, 1'b0);
        ALU_OUT = 32'hCAFEBABE; BYTE_LEN = 2'd3; OUT_Valid = 1'b1;
        exp_bytes[0] = 8'hBE; exp_bytes[1] = 8'hBA; exp_bytes[2] = 8'hFE; exp_bytes[3] = 8'hCA;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            OUT_Valid = 1'b0;
            settle();
            chk_out($sformatf("rst.new.b%0d", i), exp_bytes[i], 1'b1, 1'b1, (i == 3));
        end
        next_cycle();
        settle();
        chk_out("rst.new.after", 8'h00, 1'b0, 1'b0, 1'b0);

        // Back-to-back: second strobe in the DONE cycle of the first
        ALU_OUT = 32'h0BADF00D; BYTE_LEN = 2'd1; OUT_Valid = 1'b1;
        next_cycle();
        OUT_Valid = 1'b0;
        settle();
        chk_out("b2b.b0", 8'h0D, 1'b1, 1'b1, 1'b0);
        next_cycle();
        ALU_OUT = 32'hFFFFFFFE; BYTE_LEN = 2'd0; OUT_Valid = 1'b1;
        settle();
        chk_out("b2b.b1", 8'hF0, 1'b1, 1'b1, 1'b1);
        next_cycle();
        OUT_Valid = 1'b0;
        settle();
        chk_out("b2b.second", 8'hFE, 1'b1, 1'b1, 1'b1);
        chk("b2b.DROP_CNT", {24'h0, DROP_CNT}, 32'd0);
        next_cycle();
        settle();
        chk_out("b2b.after", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_result_packer.md
Name: alu_result_packer

Overview:
- Consumer end of the ALU result interface. Captures the ALU result word on each OUT_Valid pulse.
- Splits the word into bytes, least-significant byte first.
- Pushes the bytes one per cycle into the UART TX FIFO write port, with backpressure from FIFO_FULL.
- Sits between the ALU output stage and the TX FIFO, under the system controller.

Parameters:
- ALU_WIDTH, 32, width of the ALU result word; must be a multiple of 8.
- NUM_BYTES, ALU_WIDTH/8, derived; maximum bytes per result.
- LEN_WIDTH, 2, width of BYTE_LEN; must satisfy 2^LEN_WIDTH >= NUM_BYTES.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous reset, active-high.
- ALU_OUT  input  ALU_WIDTH  ALU result word; valid only while OUT_Valid=1.
- OUT_Valid  input  1  single-cycle result strobe.
- BYTE_LEN  input  LEN_WIDTH  bytes to send minus one; sampled together with ALU_OUT.
- FIFO_FULL  input  1  TX FIFO full; no write is allowed while it is 1.
- WR_DATA  output  8  byte presented to the FIFO.
- WR_INC  output  1  FIFO write enable; one byte is transferred per cycle it is high.
- BUSY  output  1  high while a result is being sent.
- DONE  output  1  one-cycle pulse in the cycle the last byte of a result is written.
- DROP_CNT  output  8  count of results dropped while busy; saturates at 255.

Behaviour:
- Reset: RST=1 at a rising CLK edge gives:
  - state IDLE; shift register 0; byte counter 0; DROP_CNT 0.
  - Outputs WR_DATA=0, WR_INC=0, BUSY=0, DONE=0.
  - Reset mid-send abandons the remaining bytes. No write occurs in the reset cycle or the following cycle.
- States: IDLE, SEND.
- IDLE:
  - If OUT_Valid=1: load shift register <= ALU_OUT, counter <= BYTE_LEN+1, go to SEND.
  - If OUT_Valid=0: stay in IDLE.
- SEND, combinational outputs:
  - WR_INC = ~FIFO_FULL.
  - WR_DATA = shift register[7:0].
  - BUSY = 1.
- SEND, on a write (WR_INC=1):
  - shift register >>= 8, zero-filled; counter decrements.
  - If the counter was 1, this is the last byte: DONE=1 that cycle and the state leaves SEND.
- SEND, on a stall (FIFO_FULL=1): WR_INC=0; shift register and counter hold; WR_DATA stays stable.
- Outside SEND: WR_INC=0, DONE=0, BUSY=0, WR_DATA=0.
- Latency: OUT_Valid in cycle N makes the first byte eligible in cycle N+1. An n-byte result with no stalls finishes in cycle N+n.
- BYTE_LEN >= NUM_BYTES: clamp to NUM_BYTES-1, i.e. send all bytes.
- OUT_Valid during SEND:
  - Not the last-write cycle: the result is dropped and DROP_CNT increments, holding at 255.
  - Same cycle as the last write (DONE=1): the new result is captured and the state stays in SEND. This gives back-to-back operation with no bubble; DROP_CNT is unchanged.
- Last byte stalled by FIFO_FULL: DONE is deferred until the cycle the write actually occurs.
- Arithmetic: ALU_OUT is treated as raw bits, with no sign handling. Negative results are sent as their two's-complement bytes.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, OUT_Valid=0 -> WR_INC=0, BUSY=0, DROP_CNT=0 throughout.
- Full word: ALU_OUT=0xA1B2C3D4, BYTE_LEN=3, FIFO_FULL=0 -> WR_DATA sequence D4, C3, B2, A1 in 4 consecutive cycles after the strobe; DONE on the A1 cycle; BUSY drops the next cycle.
- Short result with stall:
  - Stimulus: ALU_OUT=0x00001234, BYTE_LEN=1; FIFO_FULL=1 for the first 3 SEND cycles.
  - Required: WR_INC=0 and WR_DATA=0x34 held during the stall; then 34, 12 are written; exactly 2 writes; then DONE.
- Drop and saturation: 300 OUT_Valid pulses during a permanently stalled send -> DROP_CNT=255; the original result completes when FIFO_FULL releases.
- Back-to-back: second OUT_Valid (0xFFFFFFFE, BYTE_LEN=0) in the DONE cycle of the first -> next cycle WR_DATA=0xFE with WR_INC=1; DROP_CNT unchanged.
- Reset mid-send: RST=1 after 2 of 4 bytes -> no further WR_INC; BUSY=0; a new strobe afterwards sends its full byte sequence correctly.
